ex_stage_param: RTL and testbench

Parametrised execute stage for the pipelined RISC-V core, sitting between the ID/EX and EX/MEM boundaries. It replaces the fixed 32-bit, BEQ-only execute stage with several extensions:
- data width set by a parameter;
- full RV32I branch compare set, plus JAL/JALR target generation;
- pipeline flush input;
- optional iterative shift-add multiplier that stalls the front end while it runs.

---
 rtl/ex_stage_param_pkg.sv | 37 +++
 rtl/ex_stage_param_seq_multiplier.sv | 67 ++++++
 rtl/ex_stage_param.sv | 147 ++++++++++++++
 tb/tb_ex_stage_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_param_pkg.sv
// Shared types for the execute stage: ALU op codes, branch funct3 codes,
// forwarding selects and multiplier FSM states.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_MUL   = 4'd11
    } alu_op_t;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ex_stage_param_seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; busy for XLEN
// cycles (start cycle + XLEN-1 RUN cycles), product valid in the DONE cycle.
module seq_multiplier import ex_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);
    localparam int CW = $clog2(XLEN);

    mul_state_t      state_q, state_d;
    logic [XLEN-1:0] mcand_q, mplier_q, acc_q;
    logic [CW-1:0]   cnt_q;
    logic            go;

    assign go = start & ~flush & (state_q == MUL_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (go) state_d = MUL_RUN;
            MUL_RUN:  begin
                if (flush)              state_d = MUL_IDLE;
                else if (cnt_q == '0)   state_d = MUL_DONE;
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    assign busy    = rst & (go | (state_q == MUL_RUN));
    assign done    = (state_q == MUL_DONE) & ~flush;
    assign product = acc_q;

    // The start cycle already folds in multiplier bit 0, so RUN only needs
    // XLEN-1 further iterations and the total busy window is XLEN cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (go) begin
                acc_q    <= op_b[0] ? op_a : '0;
                mcand_q  <= op_a << 1;
                mplier_q <= op_b >> 1;
                cnt_q    <= CW'(XLEN - 2);
            end else if (state_q == MUL_RUN) begin
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_stage_param.sv
// Execute stage: forwarding, ALU, branch/jump redirect and EX/MEM register.
// One cycle for non-MUL ops; MUL holds ex_busy high XLEN cycles and bubbles EX/MEM.
module ex_stage_param import ex_pkg::*; #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write_e,
    input  logic              mem_write_e,
    input  logic              branch_e,
    input  logic              jump_e,
    input  logic              jalr_e,
    input  logic              alu_src_e,
    input  logic [1:0]        result_src_e,
    input  logic [3:0]        alu_ctrl_e,
    input  logic [2:0]        br_func_e,
    input  logic [XLEN-1:0]   rd1_e,
    input  logic [XLEN-1:0]   rd2_e,
    input  logic [XLEN-1:0]   imm_e,
    input  logic [XLEN-1:0]   pc_e,
    input  logic [XLEN-1:0]   pc_plus4_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [XLEN-1:0]   result_w,
    input  logic [1:0]        fwd_a_e,
    input  logic [1:0]        fwd_b_e,
    input  logic              flush_e,
    output logic              ex_busy,
    output logic              pc_src_e,
    output logic [XLEN-1:0]   pc_target_e,
    output logic              reg_write_m,
    output logic              mem_write_m,
    output logic [1:0]        result_src_m,
    output logic [REG_AW-1:0] rd_m,
    output logic [XLEN-1:0]   pc_plus4_m,
    output logic [XLEN-1:0]   write_data_m,
    output logic [XLEN-1:0]   alu_result_m
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_y, mul_product, jalr_sum;
    logic [SHW-1:0]  shamt;
    logic            mul_done, cond;

    always_comb begin
        case (fwd_a_e)
            FWD_W:   src_a = result_w;
            FWD_M:   src_a = alu_result_m;
            default: src_a = rd1_e;
        endcase
        case (fwd_b_e)
            FWD_W:   fwd_b = result_w;
            FWD_M:   fwd_b = alu_result_m;
            default: fwd_b = rd2_e;
        endcase
    end

    assign src_b = alu_src_e ? imm_e : fwd_b;
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        alu_y = '0;
        case (alu_ctrl_e)
            ALU_ADD:   alu_y = src_a + src_b;
            ALU_SUB:   alu_y = src_a - src_b;
            ALU_AND:   alu_y = src_a & src_b;
            ALU_OR:    alu_y = src_a | src_b;
            ALU_XOR:   alu_y = src_a ^ src_b;
            ALU_SLT:   alu_y = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU:  alu_y = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_SLL:   alu_y = src_a << shamt;
            ALU_SRL:   alu_y = src_a >> shamt;
            ALU_SRA:   alu_y = $unsigned($signed(src_a) >>> shamt);
            ALU_PASSB: alu_y = src_b;
            ALU_MUL:   alu_y = mul_done ? mul_product : '0;
            default:   alu_y = '0;
        endcase
    end

    // Branches always compare the register operands, never the immediate.
    always_comb begin
        cond = 1'b0;
        case (br_func_e)
            BR_EQ:   cond = (src_a == fwd_b);
            BR_NE:   cond = (src_a != fwd_b);
            BR_LT:   cond = ($signed(src_a) <  $signed(fwd_b));
            BR_GE:   cond = ($signed(src_a) >= $signed(fwd_b));
            BR_LTU:  cond = (src_a <  fwd_b);
            BR_GEU:  cond = (src_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign jalr_sum    = src_a + imm_e;
    assign pc_target_e = jalr_e ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_e + imm_e);
    assign pc_src_e    = ((branch_e & cond) | jump_e) & ~flush_e & ~ex_busy;

    generate
        if (MUL_EN != 0) begin : g_mul
            seq_multiplier #(.XLEN(XLEN)) u_mul (
                .clk     (clk),
                .rst     (rst),
                .start   (alu_ctrl_e == ALU_MUL),
                .flush   (flush_e),
                .op_a    (src_a),
                .op_b    (src_b),
                .busy    (ex_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign ex_busy     = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= '0;
            rd_m         <= '0;
            pc_plus4_m   <= '0;
            write_data_m <= '0;
            alu_result_m <= '0;
        end else if (ex_busy | flush_e) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= '0;
            rd_m         <= '0;
            pc_plus4_m   <= '0;
            write_data_m <= '0;
            alu_result_m <= '0;
        end else begin
            reg_write_m  <= reg_write_e;
            mem_write_m  <= mem_write_e;
            result_src_m <= result_src_e;
            rd_m         <= rd_e;
            pc_plus4_m   <= pc_plus4_e;
            write_data_m <= fwd_b;
            alu_result_m <= alu_y;
        end
    end

endmodule

// File: tb/tb_ex_stage_param.sv
// Scoreboard bench for ex_stage_param: stimulus pushes expected EX/MEM writes,
// a negedge monitor pops and compares every non-bubble EX/MEM output.
module tb_ex_stage_param;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e;
    logic [1:0]  result_src_e;
    logic [3:0]  alu_ctrl_e;
    logic [2:0]  br_func_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e, result_w;
    logic [4:0]  rd_e;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic        flush_e;
    logic        ex_busy, pc_src_e;
    logic [31:0] pc_target_e;
    logic        reg_write_m, mem_write_m;
    logic [1:0]  result_src_m;
    logic [4:0]  rd_m;
    logic [31:0] pc_plus4_m, write_data_m, alu_result_m;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    ex_stage_param #(.XLEN(32), .REG_AW(5), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .branch_e(branch_e),
        .jump_e(jump_e), .jalr_e(jalr_e), .alu_src_e(alu_src_e),
        .result_src_e(result_src_e), .alu_ctrl_e(alu_ctrl_e), .br_func_e(br_func_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .rd_e(rd_e), .result_w(result_w), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .flush_e(flush_e), .ex_busy(ex_busy), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
        .rd_m(rd_m), .pc_plus4_m(pc_plus4_m), .write_data_m(write_data_m),
        .alu_result_m(alu_result_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        reg_write_e = 0; mem_write_e = 0; branch_e = 0; jump_e = 0; jalr_e = 0;
        alu_src_e = 0; result_src_e = 0; alu_ctrl_e = ALU_ADD; br_func_e = 0;
        rd1_e = 0; rd2_e = 0; imm_e = 0; pc_e = 0; pc_plus4_e = 0; rd_e = 0;
        result_w = 0; fwd_a_e = FWD_RF; fwd_b_e = FWD_RF; flush_e = 0;
    endtask

    task automatic put(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic asrc, input logic [4:0] rd);
        nop();
        alu_ctrl_e = op; rd1_e = a; rd2_e = b; imm_e = im; alu_src_e = asrc;
        rd_e = rd; reg_write_e = 1'b1;
    endtask

    task automatic expect_wb(input logic [31:0] alu, input logic [31:0] wd,
                             input logic [31:0] pc4, input logic [4:0] rd);
        exp_t e;
        e.alu = alu; e.wd = wd; e.pc4 = pc4; e.rd = rd;
        sb.push_back(e);
    endtask

    // Monitor: every non-bubble EX/MEM output must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && (reg_write_m || mem_write_m)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wb actual rd=%0d alu=%0h required none", rd_m, alu_result_m);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_alu", {32'd0, alu_result_m}, {32'd0, e.alu});
                chk("wb_wdata", {32'd0, write_data_m}, {32'd0, e.wd});
                chk("wb_pc4", {32'd0, pc_plus4_m}, {32'd0, e.pc4});
                chk("wb_rd", {59'd0, rd_m}, {59'd0, e.rd});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[12];
        int   cnt;
        int   bad;

        v[0]  = '{ALU_ADD,   32'hFFFF_FFFF, 32'h2,         32'h1};
        v[1]  = '{ALU_SUB,   32'h3,         32'h5,         32'hFFFF_FFFE};
        v[2]  = '{ALU_AND,   32'hF0F0,      32'hFF00,      32'hF000};
        v[3]  = '{ALU_OR,    32'hF0F0,      32'h0F0F,      32'hFFFF};
        v[4]  = '{ALU_XOR,   32'hFF,        32'h0F,        32'hF0};
        v[5]  = '{ALU_SLT,   32'hFFFF_FFFF, 32'h1,         32'h1};
        v[6]  = '{ALU_SLTU,  32'hFFFF_FFFF, 32'h1,         32'h0};
        v[7]  = '{ALU_SLL,   32'h1,         32'h3F,        32'h8000_0000};
        v[8]  = '{ALU_SRL,   32'h8000_0000, 32'h4,         32'h0800_0000};
        v[9]  = '{ALU_SRA,   32'h8000_0000, 32'h4,         32'hF800_0000};
        v[10] = '{ALU_PASSB, 32'h0,         32'h1234,      32'h1234};
        v[11] = '{4'd13,     32'h5,         32'h6,         32'h0};

        rst = 1'b0;
        nop();
        step(); step(); step();
        chk("reset_reg_write_m", {63'd0, reg_write_m}, 64'd0);
        chk("reset_alu_result_m", {32'd0, alu_result_m}, 64'd0);
        chk("reset_ex_busy", {63'd0, ex_busy}, 64'd0);
        rst = 1'b1;
        step();

        // Forwarding: first make alu_result_m = 9, then forward it into src_a.
        put(ALU_ADD, 32'd9, 32'd0, 32'd0, 1'b1, 5'd1);
        expect_wb(32'd9, 32'd0, 32'd0, 5'd1);
        step();
        put(ALU_ADD, 32'd5, 32'd0, 32'd3, 1'b1, 5'd2);
        fwd_a_e = FWD_M; fwd_b_e = FWD_W; result_w = 32'h55; pc_plus4_e = 32'h44;
        expect_wb(32'd12, 32'h55, 32'h44, 5'd2);
        step();
        put(ALU_SUB, 32'd0, 32'd30, 32'd0, 1'b0, 5'd3);
        fwd_a_e = FWD_W; result_w = 32'd100;
        expect_wb(32'd70, 32'd30, 32'd0, 5'd3);
        step();

        for (int i = 0; i < 12; i++) begin
            put(v[i].op, v[i].a, v[i].b, 32'd0, 1'b0, 5'(i + 4));
            expect_wb(v[i].y, v[i].b, 32'd0, 5'(i + 4));
            step();
        end
        nop();
        step();

        // Flushed ALU op must not reach EX/MEM.
        put(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd20);
        flush_e = 1'b1;
        step();
        nop();
        chk("flush_alu_bubble", {63'd0, reg_write_m}, 64'd0);

        // Branch compares: src_a = -1, fwd_b = 1, imm deliberately different.
        nop();
        branch_e = 1; rd1_e = 32'hFFFF_FFFF; rd2_e = 32'd1; pc_e = 32'h100;
        imm_e = 32'h20; alu_src_e = 1;
        br_func_e = BR_LT;  #1; chk("blt_taken", {63'd0, pc_src_e}, 64'd1);
        chk("br_target", {32'd0, pc_target_e}, 64'h120);
        br_func_e = BR_LTU; #1; chk("bltu_not_taken", {63'd0, pc_src_e}, 64'd0);
        br_func_e = BR_GEU; #1; chk("bgeu_taken", {63'd0, pc_src_e}, 64'd1);
        br_func_e = BR_GE;  #1; chk("bge_not_taken", {63'd0, pc_src_e}, 64'd0);
        br_func_e = 3'b010; #1; chk("f010_not_taken", {63'd0, pc_src_e}, 64'd0);
        rd2_e = 32'hFFFF_FFFF;
        br_func_e = BR_EQ;  #1; chk("beq_taken", {63'd0, pc_src_e}, 64'd1);
        br_func_e = BR_NE;  #1; chk("bne_not_taken", {63'd0, pc_src_e}, 64'd0);
        br_func_e = BR_EQ; flush_e = 1; #1; chk("flush_kills_redirect", {63'd0, pc_src_e}, 64'd0);
        step();

        nop();
        jump_e = 1; jalr_e = 1; rd1_e = 32'h1003; imm_e = 32'h4;
        #1;
        chk("jalr_target", {32'd0, pc_target_e}, 64'h1006);
        chk("jalr_taken", {63'd0, pc_src_e}, 64'd1);
        step();

        // MUL 7 * 0xFFFFFFFD
        put(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'd0, 1'b0, 5'd5);
        expect_wb(32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'd0, 5'd5);
        #1;
        cnt = 0; bad = 0;
        while (ex_busy && cnt < 40) begin
            cnt++;
            @(posedge clk); #2;
            if (reg_write_m) bad++;
        end
        chk("mul_busy_cycles", 64'(cnt), 64'd32);
        chk("mul_bubbles", 64'(bad), 64'd0);
        @(posedge clk); #1;
        nop();
        chk("mul_result_reg_write", {63'd0, reg_write_m}, 64'd1);
        step();

        // Flush in RUN aborts the multiply.
        put(ALU_MUL, 32'd7, 32'd3, 32'd0, 1'b0, 5'd6);
        step();
        for (int i = 0; i < 9; i++) step();
        flush_e = 1'b1;
        step();
        nop();
        #1;
        chk("flush_busy_low", {63'd0, ex_busy}, 64'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rd_m == 5'd6) cnt++;
        end
        chk("flush_no_mul_wb", 64'(cnt), 64'd0);

        // Reset mid-RUN, then a plain ADD.
        put(ALU_MUL, 32'd7, 32'd3, 32'd0, 1'b0, 5'd7);
        for (int i = 0; i < 6; i++) step();
        rst = 1'b0;
        #1;
        chk("rst_busy", {63'd0, ex_busy}, 64'd0);
        chk("rst_reg_write_m", {63'd0, reg_write_m}, 64'd0);
        chk("rst_rd_m", {59'd0, rd_m}, 64'd0);
        chk("rst_alu_result_m", {32'd0, alu_result_m}, 64'd0);
        nop();
        step();
        rst = 1'b1;
        step();
        put(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd8);
        expect_wb(32'd2, 32'd1, 32'd0, 5'd8);
        step();
        nop();
        step(); step();

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
